// File: rtl/uart_cmd_ctrl.sv
// UART command controller: parses framed command packets, updates channel
// trigger/vector registers and trig_en, and returns one response byte per command.
module uart_cmd_ctrl #(
   parameter int unsigned TIMEOUT_CYC = 12000,
   parameter logic [7:0]  ACK         = 8'h06,
   parameter logic [7:0]  NAK         = 8'h15
) (
   input  logic       clk,
   input  logic       nrst,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   input  logic       tx_ready,
   output logic [7:0] tx_data,
   output logic       tx_start,
   output logic [7:0] trigout_ch0,
   output logic [7:0] trigout_ch1,
   output logic [7:0] trigout_ch2,
   output logic [7:0] trigout_ch3,
   output logic [7:0] vctrout_ch0,
   output logic [7:0] vctrout_ch1,
   output logic [7:0] vctrout_ch2,
   output logic [7:0] vctrout_ch3,
   output logic       trig_en,
   output logic       busy,
   output logic       err
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_ARG1 = 3'd1;
   localparam logic [2:0] S_ARG2 = 3'd2;
   localparam logic [2:0] S_ARG3 = 3'd3;
   localparam logic [2:0] S_RESP = 3'd4;

   localparam logic [7:0] H_WR = 8'h53;
   localparam logic [7:0] H_EN = 8'h5C;
   localparam logic [7:0] H_RD = 8'hA5;

   localparam logic [15:0] TO_LIM = TIMEOUT_CYC[15:0];

   logic [2:0]  r_state;
   logic [7:0]  r_hdr;
   logic [7:0]  r_b1;
   logic [7:0]  r_b2;
   logic [15:0] r_cnt;
   logic [7:0]  r_trig [4];
   logic [7:0]  r_vctr [4];
   logic        r_trig_en;
   logic [7:0]  r_tx_data;
   logic        r_tx_start;
   logic        r_busy;
   logic        r_err;

   logic        w_hdr_ok;
   logic        w_exec;
   logic [7:0]  w_sel;
   logic        w_ch_ok;
   logic        w_sel_ok;
   logic [1:0]  w_idx;
   logic [7:0]  w_rd_val;
   logic [15:0] w_cnt_nxt;
   logic        w_to;
   logic        w_in_arg;

   assign w_hdr_ok = (rx_data == H_WR) || (rx_data == H_EN) ||
                     (rx_data == H_RD);

   assign w_in_arg = (r_state == S_ARG1) || (r_state == S_ARG2) ||
                     (r_state == S_ARG3);

   // The final byte of a packet is consumed straight from rx_data.
   assign w_exec = rx_valid &&
                   (((r_state == S_ARG1) && (r_hdr == H_EN)) ||
                    ((r_state == S_ARG2) && (r_hdr == H_RD)) ||
                    (r_state == S_ARG3));

   assign w_sel    = (r_state == S_ARG2) ? rx_data : r_b2;
   assign w_ch_ok  = (r_b1 < 8'd4);
   assign w_sel_ok = (w_sel == 8'h01) || (w_sel == 8'h02);
   assign w_idx    = r_b1[1:0];
   assign w_rd_val = (w_sel == 8'h01) ? r_trig[w_idx] : r_vctr[w_idx];

   assign w_cnt_nxt = (r_cnt == 16'hFFFF) ? r_cnt : r_cnt + 16'd1;
   assign w_to      = (w_cnt_nxt == TO_LIM);

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_state    <= S_IDLE;
         r_hdr      <= '0;
         r_b1       <= '0;
         r_b2       <= '0;
         r_cnt      <= '0;
         r_trig_en  <= 1'b0;
         r_tx_data  <= '0;
         r_tx_start <= 1'b0;
         r_busy     <= 1'b0;
         r_err      <= 1'b0;
         for (int i = 0; i < 4; i++) begin
            r_trig[i] <= '0;
            r_vctr[i] <= '0;
         end
      end else begin
         r_tx_start <= 1'b0;
         r_err      <= 1'b0;
         case (r_state)
            S_IDLE: begin
               r_cnt <= '0;
               if (rx_valid) begin
                  if (w_hdr_ok) begin
                     r_hdr   <= rx_data;
                     r_state <= S_ARG1;
                     r_busy  <= 1'b1;
                  end else begin
                     r_err <= 1'b1;
                  end
               end
            end
            S_ARG1, S_ARG2, S_ARG3: begin
               if (w_exec) begin
                  r_cnt   <= '0;
                  r_state <= S_RESP;
                  r_tx_data <= NAK;
                  unique case (1'b1)
                     (r_hdr == H_EN): begin
                        if (rx_data[7:1] == 7'd0) begin
                           r_trig_en <= rx_data[0];
                           r_tx_data <= ACK;
                        end
                     end
                     (r_hdr == H_RD): begin
                        if (w_ch_ok && w_sel_ok)
                           r_tx_data <= w_rd_val;
                     end
                     default: begin
                        if (w_ch_ok && w_sel_ok) begin
                           if (w_sel == 8'h01)
                              r_trig[w_idx] <= rx_data;
                           else
                              r_vctr[w_idx] <= rx_data;
                           r_tx_data <= ACK;
                        end
                     end
                  endcase
               end else if (rx_valid) begin
                  r_cnt <= '0;
                  if (r_state == S_ARG1) begin
                     r_b1    <= rx_data;
                     r_state <= S_ARG2;
                  end else begin
                     r_b2    <= rx_data;
                     r_state <= S_ARG3;
                  end
               end else if (w_to) begin
                  r_cnt   <= '0;
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
                  r_err   <= 1'b1;
                  r_hdr   <= '0;
                  r_b1    <= '0;
                  r_b2    <= '0;
               end else begin
                  r_cnt <= w_cnt_nxt;
               end
            end
            S_RESP: begin
               r_cnt <= '0;
               // Bytes arriving while a response is pending are overruns.
               if (rx_valid)
                  r_err <= 1'b1;
               if (tx_ready) begin
                  r_tx_start <= 1'b1;
                  r_state    <= S_IDLE;
                  r_busy     <= 1'b0;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign tx_data     = r_tx_data;
   assign tx_start    = r_tx_start;
   assign trigout_ch0 = r_trig[0];
   assign trigout_ch1 = r_trig[1];
   assign trigout_ch2 = r_trig[2];
   assign trigout_ch3 = r_trig[3];
   assign vctrout_ch0 = r_vctr[0];
   assign vctrout_ch1 = r_vctr[1];
   assign vctrout_ch2 = r_vctr[2];
   assign vctrout_ch3 = r_vctr[3];
   assign trig_en     = r_trig_en;
   assign busy        = r_busy;
   assign err         = r_err;

   logic w_unused;
   assign w_unused = w_in_arg;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Directed bench for uart_cmd_ctrl: write, read-back, rejection,
// timeout, overrun and mid-packet reset scenarios.
module tb_uart_cmd_ctrl;

   logic       clk;
   logic       nrst;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       tx_ready;
   logic [7:0] tx_data;
   logic       tx_start;
   logic [7:0] trigout_ch0, trigout_ch1, trigout_ch2, trigout_ch3;
   logic [7:0] vctrout_ch0, vctrout_ch1, vctrout_ch2, vctrout_ch3;
   logic       trig_en;
   logic       busy;
   logic       err;

   int n_run;
   int n_fail;
   int n_tx;
   int n_err;
   int n_dbl;
   int n_mark;
   int e_mark;
   logic prev_start;

   uart_cmd_ctrl #(
      .TIMEOUT_CYC(20),
      .ACK(8'h06),
      .NAK(8'h15)
   ) dut (
      .clk(clk),
      .nrst(nrst),
      .rx_data(rx_data),
      .rx_valid(rx_valid),
      .tx_ready(tx_ready),
      .tx_data(tx_data),
      .tx_start(tx_start),
      .trigout_ch0(trigout_ch0),
      .trigout_ch1(trigout_ch1),
      .trigout_ch2(trigout_ch2),
      .trigout_ch3(trigout_ch3),
      .vctrout_ch0(vctrout_ch0),
      .vctrout_ch1(vctrout_ch1),
      .vctrout_ch2(vctrout_ch2),
      .vctrout_ch3(vctrout_ch3),
      .trig_en(trig_en),
      .busy(busy),
      .err(err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      n_tx = 0;
      n_err = 0;
      n_dbl = 0;
      prev_start = 1'b0;
   end

   always @(negedge clk) begin
      if (tx_start) begin
         n_tx = n_tx + 1;
         if (prev_start)
            n_dbl = n_dbl + 1;
      end
      if (err)
         n_err = n_err + 1;
      prev_start = tx_start;
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_run = n_run + 1;
      if (got !== exp) begin
         n_fail = n_fail + 1;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic send(input logic [7:0] b);
      @(negedge clk);
      rx_data  = b;
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   task automatic resp(input string tag, input logic [7:0] exp);
      repeat (4) @(negedge clk);
      chk({tag, "_cnt"}, n_tx - n_mark, 1);
      chk({tag, "_byte"}, tx_data, exp);
      chk({tag, "_busy"}, busy, 0);
   endtask

   task automatic chk_ch(input string tag,
                         input logic [7:0] t0, input logic [7:0] t1,
                         input logic [7:0] t2, input logic [7:0] t3,
                         input logic [7:0] v0, input logic [7:0] v1,
                         input logic [7:0] v2, input logic [7:0] v3);
      chk({tag, "_t0"}, trigout_ch0, t0);
      chk({tag, "_t1"}, trigout_ch1, t1);
      chk({tag, "_t2"}, trigout_ch2, t2);
      chk({tag, "_t3"}, trigout_ch3, t3);
      chk({tag, "_v0"}, vctrout_ch0, v0);
      chk({tag, "_v1"}, vctrout_ch1, v1);
      chk({tag, "_v2"}, vctrout_ch2, v2);
      chk({tag, "_v3"}, vctrout_ch3, v3);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      n_run = 0;
      n_fail = 0;
      nrst = 1'b0;
      rx_data = 8'h00;
      rx_valid = 1'b0;
      tx_ready = 1'b1;
      repeat (3) @(negedge clk);
      chk_ch("rst", 0, 0, 0, 0, 0, 0, 0, 0);
      chk("rst_en", trig_en, 0);
      chk("rst_txd", tx_data, 0);
      chk("rst_start", tx_start, 0);
      chk("rst_busy", busy, 0);
      chk("rst_err", err, 0);
      nrst = 1'b1;
      @(negedge clk);

      // write with latency check
      n_mark = n_tx;
      send(8'h53);
      chk("wr_busy", busy, 1);
      send(8'h01);
      send(8'h01);
      send(8'h7F);
      chk("wr_start0", tx_start, 0);
      chk("wr_t1", trigout_ch1, 8'h7F);
      chk("wr_txd", tx_data, 8'h06);
      @(negedge clk);
      chk("wr_start1", tx_start, 1);
      chk("wr_busy1", busy, 0);
      resp("wr", 8'h06);
      chk_ch("wr", 0, 8'h7F, 0, 0, 0, 0, 0, 0);

      // enable and read back
      n_mark = n_tx;
      send(8'h5C);
      send(8'h01);
      resp("en", 8'h06);
      chk("en_val", trig_en, 1);
      n_mark = n_tx;
      send(8'h53);
      send(8'h02);
      send(8'h02);
      send(8'hA5);
      resp("wr2", 8'h06);
      n_mark = n_tx;
      send(8'hA5);
      send(8'h02);
      send(8'h02);
      resp("rd", 8'hA5);
      n_mark = n_tx;
      send(8'hA5);
      send(8'h01);
      send(8'h01);
      resp("rd_t1", 8'h7F);

      // rejections
      n_mark = n_tx;
      send(8'h53);
      send(8'h04);
      send(8'h01);
      send(8'h55);
      resp("nak_ch", 8'h15);
      n_mark = n_tx;
      send(8'h53);
      send(8'h00);
      send(8'h03);
      send(8'h55);
      resp("nak_sel", 8'h15);
      n_mark = n_tx;
      send(8'h5C);
      send(8'h02);
      resp("nak_arg", 8'h15);
      chk("nak_en", trig_en, 1);
      chk_ch("nak", 0, 8'h7F, 0, 0, 0, 0, 8'hA5, 0);
      n_mark = n_tx;
      e_mark = n_err;
      send(8'h11);
      chk("unk_err", err, 1);
      chk("unk_busy", busy, 0);
      repeat (4) @(negedge clk);
      chk("unk_ntx", n_tx - n_mark, 0);
      chk("unk_nerr", n_err - e_mark, 1);

      // inter-byte timeout
      n_mark = n_tx;
      send(8'h53);
      send(8'h00);
      repeat (19) @(negedge clk);
      chk("to_busy19", busy, 1);
      chk("to_err19", err, 0);
      @(negedge clk);
      chk("to_err", err, 1);
      chk("to_busy", busy, 0);
      @(negedge clk);
      chk("to_err_off", err, 0);
      repeat (3) @(negedge clk);
      chk("to_ntx", n_tx - n_mark, 0);
      n_mark = n_tx;
      send(8'h5C);
      send(8'h00);
      resp("to_next", 8'h06);
      chk("to_en", trig_en, 0);

      // backpressure and overrun
      tx_ready = 1'b0;
      n_mark = n_tx;
      send(8'h53);
      send(8'h03);
      send(8'h02);
      send(8'hAA);
      send(8'h5C);
      chk("ovr_err", err, 1);
      chk("ovr_busy", busy, 1);
      repeat (5) @(negedge clk);
      chk("ovr_ntx", n_tx - n_mark, 0);
      chk("ovr_busy2", busy, 1);
      tx_ready = 1'b1;
      resp("ovr", 8'h06);
      chk("ovr_v3", vctrout_ch3, 8'hAA);
      repeat (3) @(negedge clk);
      chk("ovr_busy3", busy, 0);
      chk("ovr_en", trig_en, 0);

      // reset mid-packet
      send(8'h53);
      send(8'h01);
      nrst = 1'b0;
      #1;
      chk_ch("mrst", 0, 0, 0, 0, 0, 0, 0, 0);
      chk("mrst_en", trig_en, 0);
      chk("mrst_txd", tx_data, 0);
      chk("mrst_busy", busy, 0);
      chk("mrst_start", tx_start, 0);
      @(negedge clk);
      nrst = 1'b1;
      n_mark = n_tx;
      send(8'h5C);
      send(8'h01);
      resp("mrst_en1", 8'h06);
      chk("mrst_en2", trig_en, 1);

      chk("no_dbl_start", n_dbl, 0);
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
